// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide execute unit. Sits beside the
//            ALU in EX. Multiplies with a one-bit-per-cycle shift-add and
//            divides with a one-bit-per-cycle restoring divider. Sign fix-up
//            is applied in a separate cycle. Divide-by-zero and signed
//            overflow finish without any iteration cycles.
// Ports    : clk       clock, rising edge
//            rst       synchronous active-high reset
//            i_start   issue request, sampled only while idle
//            i_funct3  0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//            i_rs1     operand A, captured on an accepted start
//            i_rs2     operand B, captured on an accepted start
//            i_flush   abort the in-flight op
//            o_busy    high in every state except IDLE (pipeline stall)
//            o_done    one-cycle pulse, o_result valid
//            o_result  result, held until the next completed op
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int                 c_CNT_W    = $clog2(XLEN);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]    c_SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           r_funct3;
  logic [XLEN-1:0]      r_op;       // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]    r_prod;     // product, or {remainder, dividend/quotient}
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_neg_q;    // operand signs differ
  logic                 r_neg_r;    // dividend negative
  logic [XLEN-1:0]      r_result;

  // ---------------- operand decode (IDLE) ----------------
  logic            w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic            w_div0, w_ovf, w_special, w_accept;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_special_res;

  assign w_is_div   = i_funct3[2];
  assign w_a_signed = (i_funct3 == 3'd1) || (i_funct3 == 3'd2) ||
                      (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
  assign w_b_signed = (i_funct3 == 3'd1) || (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
  assign w_a_neg    = w_a_signed & i_rs1[XLEN-1];
  assign w_b_neg    = w_b_signed & i_rs2[XLEN-1];
  assign w_a_mag    = w_a_neg ? -i_rs1 : i_rs1;
  assign w_b_mag    = w_b_neg ? -i_rs2 : i_rs2;

  assign w_div0     = w_is_div & (i_rs2 == '0);
  // Signed overflow only exists for DIV/REM (funct3[0]==0 within the divide group).
  assign w_ovf      = w_is_div & ~i_funct3[0] & (i_rs1 == c_SMIN) & (i_rs2 == '1);
  assign w_special  = w_div0 | w_ovf;
  assign w_accept   = (r_state == S_IDLE) & i_start & ~i_flush;

  always_comb begin
    w_special_res = '0;
    if (w_div0) begin
      w_special_res = i_funct3[1] ? i_rs1 : '1;
    end else if (w_ovf) begin
      w_special_res = i_funct3[1] ? '0 : i_rs1;
    end
  end

  // ---------------- iteration step (CALC) ----------------
  logic [XLEN:0]     w_mul_sum, w_trial;
  logic [2*XLEN-1:0] w_mul_next, w_div_next;

  // Shift-add: conditionally add the multiplicand to the upper half, then
  // shift the whole accumulator right; the multiplier drains out the bottom.
  assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_op} : '0);
  assign w_mul_next = {w_mul_sum, r_prod[XLEN-1:1]};

  // Restoring divide: trial-subtract the divisor from the shifted partial
  // remainder; the quotient bit enters at the bottom as the dividend shifts out.
  assign w_trial    = r_prod[2*XLEN-1:XLEN-1] - {1'b0, r_op};
  assign w_div_next = w_trial[XLEN] ? {r_prod[2*XLEN-2:0], 1'b0}
                                    : {w_trial[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};

  // ---------------- sign fix-up (FIX) ----------------
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_fix_res;

  assign w_prod_fix = r_neg_q ? -r_prod : r_prod;
  assign w_quo_fix  = r_neg_q ? -r_prod[XLEN-1:0] : r_prod[XLEN-1:0];
  assign w_rem_fix  = r_neg_r ? -r_prod[2*XLEN-1:XLEN] : r_prod[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    case (r_funct3)
      3'd0:                w_fix_res = w_prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          w_fix_res = w_quo_fix;
      default:             w_fix_res = w_rem_fix;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start && !i_flush) w_next = w_special ? S_DONE : S_CALC;
      S_CALC: begin
        if (i_flush)                  w_next = S_IDLE;
        else if (r_cnt == c_CNT_LAST) w_next = S_FIX;
      end
      S_FIX:   w_next = i_flush ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3 <= '0;
      r_op     <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3 <= i_funct3;
            r_cnt    <= '0;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_op     <= w_is_div ? w_b_mag : w_a_mag;
            r_prod   <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            if (w_special) r_result <= w_special_res;
          end
        end
        S_CALC: begin
          r_prod <= r_funct3[2] ? w_div_next : w_mul_next;
          r_cnt  <= r_cnt + c_CNT_W'(1);
        end
        S_FIX: begin
          if (!i_flush) r_result <= w_fix_res;
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit (XLEN=32). Directed vector
//            table, random ops against a reference model, and hand-written
//            sequences for flush, ignored start, mid-op reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            i_start;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic            i_flush;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_funct3 (i_funct3),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_flush  (i_flush),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] as_, bs_;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    as_ = a;
    bs_ = b;
    p = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return as_ / bs_;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return as_ % bs_;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && ((b == 32'd0) ||
                    (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Waits (bounded) for IDLE, then presents a one-cycle start pulse.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (o_busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    i_start  = 1'b1;
    i_funct3 = f;
    i_rs1    = a;
    i_rs2    = b;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  // Issues one op and waits for done. inject_e >= 0 pulses a bogus start
  // that many cycles after acceptance.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r,
                        input int exp_lat, input int inject_e);
    int e, nb;
    bit got;
    logic [31:0] want;
    issue(f, a, b);
    exp_q.push_back(exp_r);
    e = 0; nb = 0; got = 1'b0;
    while (!got && e <= XLEN + 4) begin
      if (o_busy) nb++;
      if (o_done) begin
        got = 1'b1;
      end else begin
        if (e == inject_e) begin
          i_start  = 1'b1;
          i_funct3 = ~f;
          i_rs1    = $urandom;
          i_rs2    = $urandom;
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
        e++;
      end
    end
    check({nm, "_done_seen"}, 64'(got), 64'd1);
    if (exp_q.size() > 0) want = exp_q.pop_front();
    else want = 32'hx;
    if (got) begin
      check({nm, "_result"}, o_result, want);
      check({nm, "_latency"}, e, exp_lat);
      check({nm, "_busy_cycles"}, nb, exp_lat + 1);
      @(posedge clk);
      #1;
      check({nm, "_idle_after"}, {o_busy, o_done, o_result}, {2'b00, want});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, nbz;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        1'b0};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         1'b0};
    vecs[8]  = '{3'd5, 32'd12345,      32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1'b1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[12] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[13] = '{3'd7, 32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF, 1'b1};
    vecs[14] = '{3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
    vecs[15] = '{3'd5, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 1'b0};
    vecs[16] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0};
    vecs[17] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};

    rst = 1'b1; i_start = 1'b0; i_funct3 = '0; i_rs1 = '0; i_rs2 = '0; i_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {o_busy, o_done, o_result}, 64'd0);
    rst = 1'b0;

    // Directed table; ops run back-to-back (start in the IDLE cycle after DONE).
    for (int i = 0; i < 18; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].special ? 0 : XLEN + 1, -1);
    end

    // Random ops against the reference model.
    for (int i = 0; i < 16; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), rf, ra, rb, ref_model(rf, ra, rb),
             is_special(rf, ra, rb) ? 0 : XLEN + 1, -1);
    end

    // Start pulsed mid-op with new operands is ignored.
    run_op("ignore_start", 3'd5, 32'd100, 32'd7, 32'd14, XLEN + 1, 5);

    // Flush 10 cycles after a DIV start.
    issue(3'd4, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    check("flush_busy", o_busy, 64'd0);
    check("flush_result", o_result, 32'd14);
    nd = 0;
    repeat (XLEN + 4) begin @(posedge clk); #1; if (o_done) nd++; end
    check("flush_no_done", nd, 0);
    check("flush_result_hold", o_result, 32'd14);

    // Start concurrent with flush is not accepted.
    @(negedge clk);
    i_start = 1'b1; i_flush = 1'b1; i_funct3 = 3'd6; i_rs1 = 32'd5; i_rs2 = 32'd0;
    @(posedge clk);
    #1;
    i_start = 1'b0; i_flush = 1'b0;
    nd = 0; nbz = 0;
    repeat (4) begin
      if (o_busy) nbz++;
      if (o_done) nd++;
      @(posedge clk);
      #1;
    end
    check("start_flush_busy", nbz, 0);
    check("start_flush_done", nd, 0);
    check("start_flush_result", o_result, 32'd14);

    // Reset mid-op clears everything and no done follows.
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midop_reset", {o_busy, o_done, o_result}, 64'd0);
    rst = 1'b0;
    nd = 0;
    repeat (XLEN + 4) begin @(posedge clk); #1; if (o_done || o_busy) nd++; end
    check("midop_reset_quiet", nd, 0);

    // Unit still works after the reset.
    run_op("after_reset", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, XLEN + 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
